adc_multich_block: RTL and testbench

ADC_MULTICH_BLOCK -- requirements
Module: adc_multich_block

---
 rtl/adc_multich_block_if.sv | 13 +
 rtl/adc_multich_block.sv | 112 +++++++++++
 tb/tb_adc_multich_block.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/adc_multich_block_if.sv
// adc_multich_block_if: register write bus for adc_multich_block
// Ports: reg_si_data (write data), reg_si_addr (write address), reg_si_rdy (write strobe).
// The master modport drives the bus and the slave modport receives it.
interface adc_multich_block_if #(
  parameter int REG_DATA_WIDTH = 16,
  parameter int REG_ADDR_WIDTH = 8
);
  logic [REG_DATA_WIDTH-1:0] reg_si_data;
  logic [REG_ADDR_WIDTH-1:0] reg_si_addr;
  logic                      reg_si_rdy;
  modport master (output reg_si_data, reg_si_addr, reg_si_rdy);
  modport slave  (input  reg_si_data, reg_si_addr, reg_si_rdy);
endinterface

// File: rtl/adc_multich_block.sv
// adc_multich_block: multichannel ADC sampler with a programmable sample clock and 2^K averaging
// Ports: clk_i/rst (sync, active-high), adc_data_i (packed raw samples), adc_oe (ADC output enable),
//   clk_o (ADC sample clock), si_data_o/si_rdy_o (averaged samples plus a one-cycle strobe),
//   reg_if (register write bus: DIV low, DIV high, CTRL, CH_EN at ADDR_BASE+0..3).
// Optional macro ADC_MC_TEST_PATTERN_EN: when it is defined, CTRL bit 8 replaces the samples with a counter pattern.
module adc_multich_block #(
  parameter int CHANNELS       = 2,
  parameter int BITS_ADC       = 8,
  parameter int CLK_DIV_WIDTH  = 32,
  parameter int ACUM_WIDTH     = 12,
  parameter int REG_DATA_WIDTH = 16,
  parameter int REG_ADDR_WIDTH = 8,
  parameter int ADDR_BASE      = 0,
  parameter logic [CLK_DIV_WIDTH-1:0] DEFAULT_CLK_DIV = '0,
  parameter int DEFAULT_K      = 3,
  parameter logic [CHANNELS-1:0] DEFAULT_CH_EN = '1
) (
  input  logic                         clk_i,
  input  logic                         rst,
  input  logic [CHANNELS*BITS_ADC-1:0] adc_data_i,
  output logic                         adc_oe,
  output logic                         clk_o,
  output logic [CHANNELS*BITS_ADC-1:0] si_data_o,
  output logic                         si_rdy_o,
  adc_multich_block_if.slave           reg_if
);
  localparam int KMAX = ACUM_WIDTH - BITS_ADC;
  localparam int DW2 = 2 * REG_DATA_WIDTH;
  typedef enum logic {RESTART, RUN} state_t;
  state_t state;
  logic [CLK_DIV_WIDTH-1:0] div, div_cnt;
  logic [DW2-1:0] div_ext;
  logic [3:0] k, k_eff;
  logic [CHANNELS-1:0] ch_en;
  logic [15:0] cnt;
  logic [REG_ADDR_WIDTH-1:0] off;
  logic mapped, last;
  logic [BITS_ADC-1:0] samp [CHANNELS];
  logic [ACUM_WIDTH-1:0] acc [CHANNELS];
  logic [ACUM_WIDTH-1:0] sum [CHANNELS];
`ifdef ADC_MC_TEST_PATTERN_EN
  logic tp_en;
  logic [BITS_ADC-1:0] tp_cnt;
`endif
  assign off = reg_if.reg_si_addr - REG_ADDR_WIDTH'(ADDR_BASE);
  assign mapped = reg_if.reg_si_rdy && off < REG_ADDR_WIDTH'(4);
  assign div_ext = DW2'(div);
  assign k_eff = int'(k) > KMAX ? 4'(KMAX) : k;
  // ~(ones << K) is 2^K-1, the count value seen at the 2^K-th capture
  assign last = cnt == ~(16'hFFFF << k_eff);
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
`ifdef ADC_MC_TEST_PATTERN_EN
      samp[i] = !ch_en[i] ? '0 : tp_en ? tp_cnt + BITS_ADC'(i) : adc_data_i[i*BITS_ADC +: BITS_ADC];
`else
      samp[i] = ch_en[i] ? adc_data_i[i*BITS_ADC +: BITS_ADC] : '0;
`endif
      sum[i] = acc[i] + ACUM_WIDTH'(samp[i]);
    end
  end
  always_ff @(posedge clk_i) begin
    adc_oe <= !rst;
    si_rdy_o <= 1'b0;
    if (rst) begin
      div <= DEFAULT_CLK_DIV;
      k <= 4'(DEFAULT_K);
      ch_en <= DEFAULT_CH_EN;
      si_data_o <= '0;
    end else if (mapped) begin
      div <= off == 0 ? CLK_DIV_WIDTH'({div_ext[DW2-1:REG_DATA_WIDTH], reg_if.reg_si_data}) :
             off == 1 ? CLK_DIV_WIDTH'({reg_if.reg_si_data, div_ext[REG_DATA_WIDTH-1:0]}) : div;
      k <= off == 2 ? reg_if.reg_si_data[3:0] : k;
      ch_en <= off == 3 ? CHANNELS'(reg_if.reg_si_data) : ch_en;
    end
    // a restart request outranks any capture or output in the same cycle
    if (rst || mapped || state == RESTART) begin
      state <= (rst || mapped) ? RESTART : RUN;
      div_cnt <= '0;
      clk_o <= 1'b0;
      cnt <= '0;
      for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
    end else if (div_cnt == div) begin
      div_cnt <= '0;
      clk_o <= !clk_o;
      if (clk_o) begin
        cnt <= last ? '0 : cnt + 16'd1;
        si_rdy_o <= last;
        for (int i = 0; i < CHANNELS; i++) begin
          acc[i] <= last ? '0 : sum[i];
          if (last) si_data_o[i*BITS_ADC +: BITS_ADC] <= BITS_ADC'(sum[i] >> k_eff);
        end
      end
    end else begin
      div_cnt <= div_cnt + CLK_DIV_WIDTH'(1);
    end
  end
`ifdef ADC_MC_TEST_PATTERN_EN
  always_ff @(posedge clk_i) begin
    if (rst) begin
      tp_en <= 1'b0;
      tp_cnt <= '0;
    end else if (mapped) begin
      tp_en <= off == 2 ? reg_if.reg_si_data[8] : tp_en;
      tp_cnt <= '0;
    end else if (state == RESTART) begin
      tp_cnt <= '0;
    end else if (div_cnt == div && clk_o) begin
      tp_cnt <= tp_cnt + BITS_ADC'(1);
    end
  end
`endif
endmodule

// File: tb/tb_adc_multich_block.sv
// tb_adc_multich_block: self-checking bench for adc_multich_block (2 channels x 8 bits)
module tb_adc_multich_block;
  logic clk_i = 1'b0;
  logic rst;
  logic [15:0] adc_data_i;
  logic adc_oe, clk_o, si_rdy_o;
  logic [15:0] si_data_o;
  adc_multich_block_if bus ();
  adc_multich_block dut (
    .clk_i(clk_i), .rst(rst), .adc_data_i(adc_data_i), .adc_oe(adc_oe), .clk_o(clk_o),
    .si_data_o(si_data_o), .si_rdy_o(si_rdy_o), .reg_if(bus)
  );
  always #5 clk_i = ~clk_i;
  typedef struct {
    logic wr;
    logic [31:0] div;
    logic [15:0] ctrl;
    logic [1:0] ch_en;
    logic rnd;
    logic [7:0] base0, base1, step;
    int n_out;
    int exp_period;
    int exp_keff;
  } vec_t;
  vec_t vecs [8];
  vec_t cur;
  logic [15:0] sb [$];
  int n_vec = 0, n_err = 0, cyc = 0, last_fall = -1, n_strb = 0, ncap = 0, ntot = 0, ntp = 0;
  int acc [2];
  logic prev_clk = 1'b0;
  logic [15:0] last_out = '0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic model_clear();
    acc[0] = 0; acc[1] = 0; ncap = 0; ntp = 0; prev_clk = 1'b0; last_fall = -1;
    sb.delete();
  endtask
  task automatic drive_data();
    adc_data_i = cur.rnd ? 16'($urandom) :
                 {8'(cur.base1 + cur.step * ntot), 8'(cur.base0 + cur.step * ntot)};
  endtask
  task automatic step(input bit restart, input bit is_rst);
    logic exp_rdy;
    logic [7:0] s;
    @(posedge clk_i);
    @(negedge clk_i);
    cyc++;
    if (restart) begin
      model_clear();
      if (is_rst) last_out = '0;
      chk("restart_rdy", {31'd0, si_rdy_o}, 0);
      chk("restart_clk_o", {31'd0, clk_o}, 0);
      chk("hold_si_data", {16'd0, si_data_o}, {16'd0, last_out});
      return;
    end
    if (prev_clk && !clk_o) begin
      if (last_fall >= 0) chk("clk_o_period", cyc - last_fall, cur.exp_period);
      last_fall = cyc;
      for (int c = 0; c < 2; c++) begin
        s = adc_data_i[c*8 +: 8];
`ifdef ADC_MC_TEST_PATTERN_EN
        if (cur.ctrl[8]) s = 8'(ntp + c);
`endif
        if (cur.ch_en[c]) acc[c] += int'(s);
      end
      ncap++; ntot++; ntp++;
      if (ncap == (1 << cur.exp_keff)) begin
        sb.push_back({8'(acc[1] >> cur.exp_keff), 8'(acc[0] >> cur.exp_keff)});
        acc[0] = 0; acc[1] = 0; ncap = 0;
      end
      drive_data();
    end
    exp_rdy = sb.size() != 0;
    if (si_rdy_o || exp_rdy) chk("strobe", {31'd0, si_rdy_o}, {31'd0, exp_rdy});
    if (exp_rdy) begin
      last_out = sb.pop_front();
      if (si_rdy_o) begin
        chk("si_data", {16'd0, si_data_o}, {16'd0, last_out});
        n_strb++;
      end
    end
    prev_clk = clk_o;
  endtask
  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    bus.reg_si_addr = a; bus.reg_si_data = d; bus.reg_si_rdy = 1'b1;
    step(rst || a < 8'd4, rst);
    bus.reg_si_rdy = 1'b0;
  endtask
  task automatic run_outs(input int n);
    int target = n_strb + n;
    int budget = cur.exp_period * (1 << cur.exp_keff) * (n + 1) + 20;
    for (int i = 0; i < budget && n_strb < target; i++) step(0, 0);
    if (n_strb < target) chk("strobe_timeout", n_strb, target);
  endtask
  task automatic apply(input int v);
    cur = vecs[v];
    if (cur.wr) begin
      wr(8'd0, cur.div[15:0]);
      wr(8'd1, cur.div[31:16]);
      wr(8'd2, cur.ctrl);
      wr(8'd3, {14'd0, cur.ch_en});
    end
    ntot = 0;
    drive_data();
  endtask
  initial begin
    //          wr    div    ctrl     en     rnd   b0     b1     step  n  per keff
    vecs[0] = '{1'b0, 32'd0, 16'h003, 2'b11, 1'b0, 8'h40, 8'h40, 8'd0, 3, 2, 3};
    vecs[1] = '{1'b1, 32'd4, 16'h000, 2'b11, 1'b0, 8'd5, 8'd100, 8'd1, 4, 10, 0};
    vecs[2] = '{1'b1, 32'd1, 16'h002, 2'b11, 1'b0, 8'd10, 8'd200, 8'd11, 3, 4, 2};
    vecs[3] = '{1'b1, 32'd0, 16'h00F, 2'b11, 1'b1, 8'd0, 8'd0, 8'd0, 2, 2, 4};
    vecs[4] = '{1'b1, 32'd0, 16'h001, 2'b10, 1'b1, 8'd0, 8'd0, 8'd0, 3, 2, 1};
    vecs[5] = '{1'b1, 32'd2, 16'h003, 2'b01, 1'b1, 8'd0, 8'd0, 8'd0, 2, 6, 3};
    vecs[6] = '{1'b1, 32'd0, 16'h003, 2'b11, 1'b1, 8'd0, 8'd0, 8'd0, 1, 2, 3};
    vecs[7] = '{1'b1, 32'd0, 16'h100, 2'b11, 1'b0, 8'h30, 8'h70, 8'd2, 4, 2, 0};
    rst = 1'b1;
    bus.reg_si_addr = '0; bus.reg_si_data = '0; bus.reg_si_rdy = 1'b0;
    adc_data_i = '0;
    cur = vecs[0];
    step(1, 1);
    wr(8'd0, 16'd5);
    step(1, 1);
    chk("rst_adc_oe", {31'd0, adc_oe}, 0);
    rst = 1'b0;
    step(0, 0);
    chk("adc_oe", {31'd0, adc_oe}, 1);
    for (int v = 0; v < 8; v++) begin
      apply(v);
      run_outs(cur.n_out);
    end
    apply(2);
    run_outs(1);
    wr(8'd7, 16'hFFFF);
    run_outs(2);
    apply(6);
    run_outs(1);
    for (int i = 0; i < 100 && !(ncap == 7 && prev_clk); i++) step(0, 0);
    chk("sync_to_capture", ncap, 7);
    wr(8'd3, 16'h0003);
    run_outs(1);
    apply(5);
    run_outs(1);
    for (int i = 0; i < 200 && ncap != 2; i++) step(0, 0);
    chk("sync_mid_average", ncap, 2);
    rst = 1'b1;
    cur = vecs[6];
    step(1, 1);
    rst = 1'b0;
    run_outs(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
